// File: rtl/pc_sequencer.sv
// Program-counter sequencer with branch, jump, jump-register, call/return
// and a circular return-address stack.
module pc_sequencer #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      RAS_DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               br_en,
  input  logic               br_ne,
  input  logic               zero,
  input  logic [WIDTH-1:0]   imm,
  input  logic               jmp_en,
  input  logic [WIDTH-3:0]   jmp_tgt,
  input  logic               link,
  input  logic               jr_en,
  input  logic [WIDTH-1:0]   jr_addr,
  input  logic               ret_en,
  output logic [WIDTH-1:0]   pc,
  output logic [WIDTH-1:0]   pc_seq,
  output logic               ras_empty,
  output logic               ras_full,
  output logic               ras_err
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_JR,
    SRC_RET,
    SRC_JMP,
    SRC_BR,
    SRC_SEQ
  } src_t;

  logic [WIDTH-1:0] stack [RAS_DEPTH];
  // top_ptr names the next free slot; the top entry sits at top_ptr-1.
  // Pushing while full lands on the oldest slot, which gives the overwrite.
  logic [PTR_W-1:0] top_ptr;
  logic [CNT_W-1:0] count;

  src_t             src;
  logic             taken;
  logic             push;
  logic             pop;
  logic             err_next;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] br_tgt;
  logic [WIDTH-1:0] ras_top;

  assign pc_seq    = pc + WIDTH'(4);
  assign taken     = br_en && (zero ^ br_ne);
  assign br_tgt    = pc_seq + (imm << 2);
  assign ras_top   = stack[top_ptr - PTR_W'(1)];
  assign ras_empty = (count == '0);
  assign ras_full  = (count == CNT_W'(RAS_DEPTH));

  // Pick the winning next-PC source by fixed priority.
  always_comb begin
    src      = SRC_SEQ;
    err_next = 1'b0;
    if (stall) begin
      src = SRC_HOLD;
    end else if (jr_en) begin
      src = SRC_JR;
    end else if (ret_en) begin
      // A return on an empty stack falls through to sequential and flags it.
      if (ras_empty) begin
        src      = SRC_SEQ;
        err_next = 1'b1;
      end else begin
        src = SRC_RET;
      end
    end else if (jmp_en) begin
      src = SRC_JMP;
    end else if (taken) begin
      src = SRC_BR;
    end
  end

  // Turn the chosen source into the next PC and stack push/pop strobes.
  always_comb begin
    pc_next = pc_seq;
    push    = 1'b0;
    pop     = 1'b0;
    case (src)
      SRC_HOLD: pc_next = pc;
      SRC_JR:   pc_next = jr_addr & ~WIDTH'(3);
      SRC_RET: begin
        pc_next = ras_top;
        pop     = 1'b1;
      end
      SRC_JMP: begin
        pc_next = {jmp_tgt, 2'b00};
        push    = link;
      end
      SRC_BR:   pc_next = br_tgt;
      default:  pc_next = pc_seq;
    endcase
  end

  // PC, stack bookkeeping and the error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_VECTOR;
      count   <= '0;
      top_ptr <= '0;
      ras_err <= 1'b0;
    end else begin
      pc      <= pc_next;
      ras_err <= err_next;
      if (push) begin
        top_ptr <= top_ptr + PTR_W'(1);
        if (!ras_full) count <= count + CNT_W'(1);
      end else if (pop) begin
        top_ptr <= top_ptr - PTR_W'(1);
        count   <= count - CNT_W'(1);
      end
    end
  end

  // Stack storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push) stack[top_ptr] <= pc_seq;
  end

endmodule
